// File: rtl/ahb_reg_slave.sv
// ahb_reg_slave: AHB-Lite register bank slave with read-back, wait states, ERROR response and write strobes
// Ports: hclk/hreset_n clock and async active-low reset; hsel/haddr/htrans/hwrite/hsize/hready address phase;
//        hwdata write data; hreadyout/hresp/hrdata slave response; reg_out flat register contents;
//        wr_pulse per-register one-cycle update strobe.
// Define AHB_REG_BYTE_STROBE_EN to enable byte/halfword writes with alignment checking.
module ahb_reg_slave #(
  parameter int          NUM_REGS    = 4,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] RESET_VAL   = 32'h0
) (
  input  logic                   hclk,
  input  logic                   hreset_n,
  input  logic                   hsel,
  input  logic [31:0]            haddr,
  input  logic [1:0]             htrans,
  input  logic                   hwrite,
  input  logic [2:0]             hsize,
  input  logic [31:0]            hwdata,
  input  logic                   hready,
  output logic                   hreadyout,
  output logic                   hresp,
  output logic [31:0]            hrdata,
  output logic [NUM_REGS*32-1:0] reg_out,
  output logic [NUM_REGS-1:0]    wr_pulse
);
  localparam int IDX_W = $clog2(NUM_REGS);
  // WAIT lasts exactly WAIT_STATES cycles, so the counter is loaded one short
  localparam logic [2:0] WS_LOAD = WAIT_STATES > 0 ? 3'(WAIT_STATES - 1) : 3'd0;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_e;
  state_e              st_q, st_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                dp_q, dp_d, wr_q;
  logic [IDX_W-1:0]    idx_q;
  logic [NUM_REGS-1:0] pulse_q, pulse_d;
  logic [31:0]         regs_q [NUM_REGS];
  logic [31:0]         regs_d [NUM_REGS];
  logic                acc, bad, fin, commit, unused_ok;
  logic [3:0]          be;
  logic [31:0]         mask, merged;
  assign acc = hsel && hready && htrans[1] && hreadyout;
`ifdef AHB_REG_BYTE_STROBE_EN
  logic [1:0] size_q, lane_q;
  assign bad = haddr[31:2] >= 30'(NUM_REGS) || hsize > 3'd2 ||
               (hsize == 3'd1 && haddr[0]) || (hsize == 3'd2 && haddr[1:0] != 2'd0);
  assign be = size_q == 2'd0 ? 4'b0001 << lane_q : size_q == 2'd1 ? (lane_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign unused_ok = htrans[0];
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      size_q <= 2'd0;
      lane_q <= 2'd0;
    end else if (acc) begin
      size_q <= hsize[1:0];
      lane_q <= haddr[1:0];
    end
  end
`else
  assign bad = haddr[31:2] >= 30'(NUM_REGS) || hsize > 3'd2;
  assign be = 4'b1111;
  assign unused_ok = ^{htrans[0], haddr[1:0]};
`endif
  assign mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  // the final data cycle of an OKAY transfer is the only IDLE cycle with a pending data phase
  assign fin = st_q == S_IDLE && dp_q;
  assign commit = fin && wr_q;
  assign merged = (regs_q[idx_q] & ~mask) | (hwdata & mask);
  assign hreadyout = st_q != S_WAIT && st_q != S_ERR1;
  assign hresp = st_q == S_ERR1 || st_q == S_ERR2;
  assign hrdata = fin && !wr_q ? regs_q[idx_q] : 32'h0;
  assign wr_pulse = pulse_q;
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[32*g +: 32] = regs_q[g];
  end
  always_comb begin
    st_d = st_q == S_WAIT ? (cnt_q == 3'd0 ? S_IDLE : S_WAIT) :
           st_q == S_ERR1 ? S_ERR2 :
           !acc ? S_IDLE : bad ? S_ERR1 : WAIT_STATES > 0 ? S_WAIT : S_IDLE;
    cnt_d = acc && !bad ? WS_LOAD : cnt_q != 3'd0 ? cnt_q - 3'd1 : cnt_q;
    dp_d = acc ? !bad : dp_q && !fin;
    pulse_d = commit ? NUM_REGS'(1) << idx_q : '0;
    for (int i = 0; i < NUM_REGS; i++) regs_d[i] = commit && idx_q == IDX_W'(i) ? merged : regs_q[i];
  end
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      st_q <= S_IDLE;
      cnt_q <= 3'd0;
      dp_q <= 1'b0;
      wr_q <= 1'b0;
      idx_q <= '0;
      pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      dp_q <= dp_d;
      pulse_q <= pulse_d;
      regs_q <= regs_d;
      if (acc) begin
        wr_q <= hwrite;
        idx_q <= haddr[IDX_W+1:2];
      end
    end
  end
endmodule

// File: tb/tb_ahb_reg_slave.sv
// tb_ahb_reg_slave: directed scenario bench for ahb_reg_slave (zero-wait and three-wait-state instances)
module tb_ahb_reg_slave;
  logic         hclk = 1'b0, hreset_n = 1'b0;
  logic         hsel0 = 1'b0, hsel3 = 1'b0, hwrite = 1'b0;
  logic [31:0]  haddr = '0, hwdata = '0;
  logic [1:0]   htrans = '0;
  logic [2:0]   hsize = '0;
  logic         hro0, hresp0, hro3, hresp3;
  logic [31:0]  rd0, rd3;
  logic [127:0] ro0, ro3;
  logic [3:0]   wp0, wp3;
  int           errs = 0, checks = 0;
  localparam logic [127:0] RST3 = {4{32'h5A5A0000}};

  always #5 hclk = ~hclk;

  ahb_reg_slave #(.NUM_REGS(4), .WAIT_STATES(0), .RESET_VAL(32'h0)) u0 (
    .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel0), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hwdata(hwdata), .hready(hro0), .hreadyout(hro0), .hresp(hresp0), .hrdata(rd0),
    .reg_out(ro0), .wr_pulse(wp0));

  ahb_reg_slave #(.NUM_REGS(4), .WAIT_STATES(3), .RESET_VAL(32'h5A5A0000)) u3 (
    .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel3), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hwdata(hwdata), .hready(hro3), .hreadyout(hro3), .hresp(hresp3), .hrdata(rd3),
    .reg_out(ro3), .wr_pulse(wp3));

  task automatic cyc;
    @(posedge hclk);
    #1;
  endtask

  task automatic addr(input logic s0, input logic s3, input logic [31:0] a, input logic w, input logic [2:0] sz);
    hsel0 = s0; hsel3 = s3; haddr = a; hwrite = w; hsize = sz; htrans = 2'd2;
  endtask

  task automatic idle;
    hsel0 = 1'b0; hsel3 = 1'b0; htrans = 2'd0;
  endtask

  task automatic test_reset;
    hreset_n = 1'b0;
    cyc; cyc;
    checks++; if (hro0 !== 1'b1) begin errs++; $display("FAIL reset_hreadyout got=%b exp=1", hro0); end
    checks++; if (hresp0 !== 1'b0) begin errs++; $display("FAIL reset_hresp got=%b exp=0", hresp0); end
    checks++; if (rd0 !== 32'h0) begin errs++; $display("FAIL reset_hrdata got=%h exp=0", rd0); end
    checks++; if (ro0 !== 128'h0) begin errs++; $display("FAIL reset_reg_out0 got=%h exp=0", ro0); end
    checks++; if (wp0 !== 4'h0) begin errs++; $display("FAIL reset_wr_pulse got=%b exp=0000", wp0); end
    checks++; if (ro3 !== RST3) begin errs++; $display("FAIL reset_reg_out3 got=%h exp=%h", ro3, RST3); end
    hreset_n = 1'b1;
    cyc;
  endtask

  task automatic test_zero_wait;
    addr(1, 0, 32'h8, 1, 3'd2);
    cyc;
    hwdata = 32'hDEADBEEF;
    addr(1, 0, 32'h8, 0, 3'd2);
    checks++; if (hro0 !== 1'b1 || hresp0 !== 1'b0) begin errs++; $display("FAIL zw_data_phase got=%b%b exp=10", hro0, hresp0); end
    cyc;
    idle;
    checks++; if (ro0[95:64] !== 32'hDEADBEEF) begin errs++; $display("FAIL zw_reg2 got=%h exp=deadbeef", ro0[95:64]); end
    checks++; if (wp0 !== 4'b0100) begin errs++; $display("FAIL zw_pulse got=%b exp=0100", wp0); end
    checks++; if (rd0 !== 32'hDEADBEEF) begin errs++; $display("FAIL zw_readback got=%h exp=deadbeef", rd0); end
    cyc;
    checks++; if (wp0 !== 4'b0000) begin errs++; $display("FAIL zw_pulse_clear got=%b exp=0000", wp0); end
    checks++; if (rd0 !== 32'h0) begin errs++; $display("FAIL zw_rdata_idle got=%h exp=0", rd0); end
  endtask

  task automatic test_error;
    hwdata = 32'h0;
    addr(1, 0, 32'h10, 1, 3'd2);
    cyc;
    hwdata = 32'h12345678;
    addr(1, 0, 32'h8, 0, 3'd2);
    checks++; if (hro0 !== 1'b0 || hresp0 !== 1'b1) begin errs++; $display("FAIL err1 got=%b%b exp=01", hro0, hresp0); end
    checks++; if (wp0 !== 4'b0000) begin errs++; $display("FAIL err1_pulse got=%b exp=0000", wp0); end
    cyc;
    checks++; if (hro0 !== 1'b1 || hresp0 !== 1'b1) begin errs++; $display("FAIL err2 got=%b%b exp=11", hro0, hresp0); end
    cyc;
    idle;
    checks++; if (hro0 !== 1'b1 || hresp0 !== 1'b0) begin errs++; $display("FAIL err_next_okay got=%b%b exp=10", hro0, hresp0); end
    checks++; if (rd0 !== 32'hDEADBEEF) begin errs++; $display("FAIL err_next_read got=%h exp=deadbeef", rd0); end
    checks++; if (ro0 !== {32'h0, 32'hDEADBEEF, 64'h0}) begin errs++; $display("FAIL err_regs got=%h exp=%h", ro0, {32'h0, 32'hDEADBEEF, 64'h0}); end
    checks++; if (wp0 !== 4'b0000) begin errs++; $display("FAIL err_pulse got=%b exp=0000", wp0); end
    cyc;
  endtask

  task automatic test_wait_states;
    int low = 0;
    logic rsp = 1'b0;
    addr(0, 1, 32'h4, 1, 3'd2);
    cyc;
    hwdata = 32'h0BADF00D;
    idle;
    while (!hro3 && low < 10) begin
      if (hresp3) rsp = 1'b1;
      low++;
      cyc;
    end
    checks++; if (low != 3) begin errs++; $display("FAIL ws_low_cycles got=%0d exp=3", low); end
    checks++; if (rsp !== 1'b0 || hresp3 !== 1'b0) begin errs++; $display("FAIL ws_hresp got=%b exp=0", rsp | hresp3); end
    checks++; if (ro3[63:32] !== 32'h5A5A0000) begin errs++; $display("FAIL ws_early_commit got=%h exp=5a5a0000", ro3[63:32]); end
    cyc;
    checks++; if (ro3[63:32] !== 32'h0BADF00D) begin errs++; $display("FAIL ws_reg1 got=%h exp=0badf00d", ro3[63:32]); end
    checks++; if (wp3 !== 4'b0010) begin errs++; $display("FAIL ws_pulse got=%b exp=0010", wp3); end
    cyc;
    checks++; if (wp3 !== 4'b0000) begin errs++; $display("FAIL ws_pulse_clear got=%b exp=0000", wp3); end
  endtask

  task automatic test_reset_mid;
    addr(0, 1, 32'hC, 1, 3'd2);
    cyc;
    hwdata = 32'hCAFEF00D;
    idle;
    cyc;
    checks++; if (hro3 !== 1'b0) begin errs++; $display("FAIL rm_in_wait got=%b exp=0", hro3); end
    hreset_n = 1'b0;
    #1;
    checks++; if (hro3 !== 1'b1 || hresp3 !== 1'b0) begin errs++; $display("FAIL rm_resp got=%b%b exp=10", hro3, hresp3); end
    checks++; if (ro3 !== RST3) begin errs++; $display("FAIL rm_regs got=%h exp=%h", ro3, RST3); end
    checks++; if (wp3 !== 4'b0000 || rd3 !== 32'h0) begin errs++; $display("FAIL rm_pulse_rdata got=%b/%h exp=0000/0", wp3, rd3); end
    cyc;
    hreset_n = 1'b1;
    for (int i = 0; i < 5; i++) cyc;
    checks++; if (ro3 !== RST3 || wp3 !== 4'b0000) begin errs++; $display("FAIL rm_discard got=%h/%b exp=%h/0000", ro3, wp3, RST3); end
  endtask

  task automatic test_strobe;
    addr(1, 0, 32'h0, 1, 3'd2);
    cyc;
    hwdata = 32'h11223344;
    idle;
    cyc;
    checks++; if (ro0[31:0] !== 32'h11223344) begin errs++; $display("FAIL sb_full got=%h exp=11223344", ro0[31:0]); end
    addr(1, 0, 32'h2, 1, 3'd0);
    cyc;
`ifdef AHB_REG_BYTE_STROBE_EN
    hwdata = 32'h00AA0000;
    idle;
    cyc;
    checks++; if (ro0[31:0] !== 32'h11AA3344) begin errs++; $display("FAIL sb_byte got=%h exp=11aa3344", ro0[31:0]); end
    checks++; if (wp0 !== 4'b0001) begin errs++; $display("FAIL sb_byte_pulse got=%b exp=0001", wp0); end
    addr(1, 0, 32'h1, 1, 3'd1);
`else
    hwdata = 32'h000000AA;
    idle;
    cyc;
    checks++; if (ro0[31:0] !== 32'h000000AA) begin errs++; $display("FAIL sb_byte got=%h exp=000000aa", ro0[31:0]); end
    checks++; if (wp0 !== 4'b0001) begin errs++; $display("FAIL sb_byte_pulse got=%b exp=0001", wp0); end
    addr(1, 0, 32'h0, 1, 3'd3);
`endif
    cyc;
    hwdata = 32'hFFFFFFFF;
    idle;
    checks++; if (hro0 !== 1'b0 || hresp0 !== 1'b1) begin errs++; $display("FAIL sb_err1 got=%b%b exp=01", hro0, hresp0); end
    cyc;
    checks++; if (hro0 !== 1'b1 || hresp0 !== 1'b1) begin errs++; $display("FAIL sb_err2 got=%b%b exp=11", hro0, hresp0); end
    cyc;
`ifdef AHB_REG_BYTE_STROBE_EN
    checks++; if (ro0[31:0] !== 32'h11AA3344) begin errs++; $display("FAIL sb_err_nochange got=%h exp=11aa3344", ro0[31:0]); end
`else
    checks++; if (ro0[31:0] !== 32'h000000AA) begin errs++; $display("FAIL sb_err_nochange got=%h exp=000000aa", ro0[31:0]); end
`endif
    checks++; if (wp0 !== 4'b0000 || hresp0 !== 1'b0) begin errs++; $display("FAIL sb_err_end got=%b/%b exp=0000/0", wp0, hresp0); end
  endtask

  initial begin
    test_reset;
    test_zero_wait;
    test_error;
    test_wait_states;
    test_reset_mid;
    test_strobe;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
